// File: rtl/obstacle_play_engine.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_play_engine
// Description : Gameplay core for the obstacle runner. Scrolls a one-row
//               obstacle field toward the player in column 0 and applies
//               jump input. Reports win/dead status to the screen controller.
//               Runs only while i_play is high; any drop of i_play returns
//               the engine to IDLE with all run state cleared.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               i_play          - high while the controller is in play
//               i_tick          - one-cycle frame pulse
//               i_jump          - one-cycle debounced button pulse
//               o_win / o_dead  - level status (never both high)
//               o_obstacles     - obstacle map, bit 0 = player column
//               o_airborne      - player is in the air
//               o_distance      - scroll steps completed this run
//               o_step          - one-cycle pulse after each scroll step
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_play_engine #(
    parameter int         COLS           = 16,
    parameter int         WIN_DIST       = 256,
    parameter int         TICKS_PER_STEP = 4,
    parameter int         JUMP_STEPS     = 3,
    parameter int         MIN_GAP        = 3,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_play,
    input  logic            i_tick,
    input  logic            i_jump,
    output logic            o_win,
    output logic            o_dead,
    output logic [COLS-1:0] o_obstacles,
    output logic            o_airborne,
    output logic [15:0]     o_distance,
    output logic            o_step
);

    localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int AW = $clog2(JUMP_STEPS + 1);
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    localparam logic [TW-1:0] c_tick_last = TW'(TICKS_PER_STEP - 1);
    localparam logic [AW-1:0] c_jump      = AW'(JUMP_STEPS);
    localparam logic [GW-1:0] c_gap       = GW'(MIN_GAP);
    localparam logic [15:0]   c_win_dist  = 16'(WIN_DIST);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_WON     = 2'd2,
        S_CRASHED = 2'd3
    } state_t;

    state_t          r_state;
    logic [7:0]      r_lfsr;
    logic [COLS-1:0] r_obs;
    logic [15:0]     r_distance;
    logic [AW-1:0]   r_air_cnt;
    logic [TW-1:0]   r_tick_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_win;
    logic            r_dead;
    logic            r_step;

    logic            w_lfsr_fb;
    logic            w_jump_load;
    logic            w_scroll;
    logic            w_new_bit;
    logic [COLS-1:0] w_nxt_obs;
    logic [AW-1:0]   w_air_after;
    logic [GW-1:0]   w_gap_nxt;
    logic [15:0]     w_dist_nxt;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // A jump is accepted only on the ground; no buffering while airborne
    assign w_jump_load = i_jump && (r_air_cnt == '0);
    assign w_scroll    = i_tick && (r_tick_cnt == c_tick_last);

    // The gap counter enforces MIN_GAP empty columns between obstacles
    assign w_new_bit   = r_lfsr[0] && (r_gap_cnt >= c_gap);
    assign w_nxt_obs   = {w_new_bit, r_obs[COLS-1:1]};
    assign w_gap_nxt   = w_new_bit ? '0 :
                         (r_gap_cnt >= c_gap) ? c_gap : r_gap_cnt + 1'b1;

    // A jump loaded on a scroll step wins over that step's decrement
    assign w_air_after = w_jump_load         ? c_jump :
                         (r_air_cnt != '0)   ? r_air_cnt - 1'b1 : '0;
    assign w_dist_nxt  = r_distance + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr     <= LFSR_SEED;
            r_state    <= S_IDLE;
            r_obs      <= '0;
            r_distance <= '0;
            r_air_cnt  <= '0;
            r_tick_cnt <= '0;
            r_gap_cnt  <= '0;
            r_win      <= 1'b0;
            r_dead     <= 1'b0;
            r_step     <= 1'b0;
        end else begin
            // Free-running in every state so run contents depend on menu time
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            r_step <= 1'b0;

            // IDLE always clears; a play drop in any other state returns
            // here with the same clear, ahead of all run activity.
            if (r_state == S_IDLE || !i_play) begin
                r_obs      <= '0;
                r_distance <= '0;
                r_air_cnt  <= '0;
                r_tick_cnt <= '0;
                r_gap_cnt  <= '0;
                r_win      <= 1'b0;
                r_dead     <= 1'b0;
                r_state    <= (r_state == S_IDLE && i_play) ? S_RUN : S_IDLE;
            end else if (r_state == S_RUN) begin
                if (w_scroll) begin
                    r_tick_cnt <= '0;
                    r_obs      <= w_nxt_obs;
                    r_gap_cnt  <= w_gap_nxt;
                    r_air_cnt  <= w_air_after;
                    r_distance <= w_dist_nxt;
                    r_step     <= 1'b1;
                    // Collision is checked first so dead beats win
                    if (w_nxt_obs[0] && (w_air_after == '0)) begin
                        r_state <= S_CRASHED;
                        r_dead  <= 1'b1;
                    end else if (w_dist_nxt == c_win_dist) begin
                        r_state <= S_WON;
                        r_win   <= 1'b1;
                    end
                end else begin
                    if (i_tick) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                    if (w_jump_load) begin
                        r_air_cnt <= c_jump;
                    end
                end
            end
            // WON / CRASHED hold everything while play stays high
        end
    end

    assign o_win       = r_win;
    assign o_dead      = r_dead;
    assign o_obstacles = r_obs;
    assign o_airborne  = (r_air_cnt != '0);
    assign o_distance  = r_distance;
    assign o_step      = r_step;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_play_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_play_engine
// Description : Self-checking bench for obstacle_play_engine. Two instances:
//               A (WIN_DIST=10, 4 ticks/step) and B (WIN_DIST=200,
//               1 tick/step). Both are compared every cycle against a
//               behavioural model built from the game rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_play_engine;

    localparam int         GAP   = 3;
    localparam int         JUMP  = 3;
    localparam logic [7:0] SEED  = 8'hA5;
    localparam int P_MENU = 0, P_PLAY = 1, P_WON = 2, P_DEAD = 3;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_play, a_tick, a_jump, b_play, b_tick, b_jump;
    logic        a_win, a_dead, a_air, a_step, b_win, b_dead, b_air, b_step;
    logic [15:0] a_obs, a_dist, b_obs, b_dist;

    obstacle_play_engine #(
        .COLS(16), .WIN_DIST(10), .TICKS_PER_STEP(4),
        .JUMP_STEPS(3), .MIN_GAP(3), .LFSR_SEED(8'hA5)
    ) u_dut_a (
        .clk(clk), .reset(rst), .i_play(a_play), .i_tick(a_tick), .i_jump(a_jump),
        .o_win(a_win), .o_dead(a_dead), .o_obstacles(a_obs), .o_airborne(a_air),
        .o_distance(a_dist), .o_step(a_step)
    );

    obstacle_play_engine #(
        .COLS(16), .WIN_DIST(200), .TICKS_PER_STEP(1),
        .JUMP_STEPS(3), .MIN_GAP(3), .LFSR_SEED(8'hA5)
    ) u_dut_b (
        .clk(clk), .reset(rst), .i_play(b_play), .i_tick(b_tick), .i_jump(b_jump),
        .o_win(b_win), .o_dead(b_dead), .o_obstacles(b_obs), .o_airborne(b_air),
        .o_distance(b_dist), .o_step(b_step)
    );

    // ---------------- behavioural model (index 0 = A, 1 = B) ----------------
    int          m_win_dist [2] = '{10, 200};
    int          m_tps      [2] = '{4, 1};
    int          m_ph       [2];
    logic [15:0] m_obs      [2];
    int          m_dist     [2];
    int          m_air      [2];
    int          m_ticks    [2];
    int          m_since    [2];   // steps since last obstacle was spawned
    logic [7:0]  m_lfsr     [2];
    bit          m_step     [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear(input int k);
        m_obs[k]   = '0;
        m_dist[k]  = 0;
        m_air[k]   = 0;
        m_ticks[k] = 0;
        m_since[k] = 0;
    endtask

    task automatic model_edge(input int k, input bit r, input bit play, input bit tick, input bit jump);
        logic [7:0] l;
        bit nb, jumped;
        l = m_lfsr[k];
        m_lfsr[k] = r ? SEED : {l[6:0], ^(l & 8'hB8)};
        m_step[k] = 1'b0;
        if (r) begin
            model_clear(k);
            m_ph[k] = P_MENU;
        end else if (m_ph[k] == P_MENU) begin
            model_clear(k);
            if (play) m_ph[k] = P_PLAY;
        end else if (!play) begin
            model_clear(k);
            m_ph[k] = P_MENU;
        end else if (m_ph[k] == P_PLAY) begin
            jumped = jump && (m_air[k] == 0);
            if (tick) m_ticks[k]++;
            if (tick && m_ticks[k] == m_tps[k]) begin
                m_ticks[k] = 0;
                nb = l[0] && (m_since[k] >= GAP);
                m_obs[k] = {nb, m_obs[k][15:1]};
                m_since[k] = nb ? 0 : m_since[k] + 1;
                if (jumped) m_air[k] = JUMP;
                else if (m_air[k] > 0) m_air[k]--;
                m_dist[k]++;
                m_step[k] = 1'b1;
                if (m_obs[k][0] && m_air[k] == 0) m_ph[k] = P_DEAD;
                else if (m_dist[k] == m_win_dist[k]) m_ph[k] = P_WON;
            end else if (jumped) begin
                m_air[k] = JUMP;
            end
        end
    endtask

    function automatic bit gap_ok(input logic [15:0] v);
        int last;
        last = -100;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                if (i - last - 1 < GAP) return 1'b0;
                last = i;
            end
        end
        return 1'b1;
    endfunction

    // One clock: model follows the edge, outputs are sampled 1 time unit later
    task automatic cycle();
        @(posedge clk);
        model_edge(0, rst, a_play, a_tick, a_jump);
        model_edge(1, rst, b_play, b_tick, b_jump);
        #1;
        check("A.obs",   a_obs,  m_obs[0]);
        check("A.dist",  a_dist, 16'(m_dist[0]));
        check("A.flags", {a_win, a_dead, a_air, a_step},
              {m_ph[0] == P_WON, m_ph[0] == P_DEAD, m_air[0] != 0, m_step[0]});
        check("B.obs",   b_obs,  m_obs[1]);
        check("B.dist",  b_dist, 16'(m_dist[1]));
        check("B.flags", {b_win, b_dead, b_air, b_step},
              {m_ph[1] == P_WON, m_ph[1] == P_DEAD, m_air[1] != 0, m_step[1]});
        check("A.gap",   32'(gap_ok(a_obs)), 32'd1);
        check("B.gap",   32'(gap_ok(b_obs)), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, crash_dist, air_cycles, steps, guard;
        bit jumped_once, fatal;

        for (int k = 0; k < 2; k++) begin
            model_clear(k);
            m_ph[k] = P_MENU;
            m_lfsr[k] = SEED;
            m_step[k] = 1'b0;
        end
        rst = 1'b1;
        a_play = 1'b1; a_tick = 1'b0; a_jump = 1'b0;
        b_play = 1'b1; b_tick = 1'b0; b_jump = 1'b0;

        // ---------------- reset held with play high ----------------
        cycle();
        cycle();
        check("rst.a_out", {a_win, a_dead, a_air, a_step, a_obs}, 32'd0);
        check("rst.b_out", {b_win, b_dead, b_air, b_step, b_dist}, 32'd0);
        rst = 1'b0; a_play = 1'b0; b_play = 1'b0;
        check("rst.lfsr", u_dut_b.r_lfsr, 32'hA5);

        // ---------------- guaranteed win on A ----------------
        d = $urandom_range(0, 7);
        repeat (d) cycle();
        a_play = 1'b1; a_tick = 1'b1;          // entry-cycle tick must be ignored
        cycle();
        a_tick = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            repeat ($urandom_range(0, 3)) cycle();
            a_tick = 1'b1;
            a_jump = ($urandom_range(0, 4) == 0);
            cycle();
            a_tick = 1'b0; a_jump = 1'b0;
            if (t == 39) check("win.early", a_win, 1'b0);
        end
        check("win.win",  a_win,  1'b1);
        check("win.dead", a_dead, 1'b0);
        check("win.dist", a_dist, 16'd10);
        for (int t = 0; t < 8; t++) begin
            a_tick = 1'b1; a_jump = t[0];
            cycle();
        end
        a_tick = 1'b0; a_jump = 1'b0;
        check("win.hold_win",  a_win,  1'b1);
        check("win.hold_dist", a_dist, 16'd10);
        a_play = 1'b0;
        cycle();

        // ---------------- crash on B, no jumps ----------------
        d = $urandom_range(0, 20);
        rst = 1'b1; cycle(); rst = 1'b0;
        repeat (d) cycle();
        b_play = 1'b1; cycle();
        b_tick = 1'b1;
        guard = 0;
        while (!b_dead && !b_win && guard < 400) begin
            cycle();
            guard++;
        end
        crash_dist = m_dist[1];
        check("crash.dead",   b_dead, 1'b1);
        check("crash.dist",   b_dist, 16'(crash_dist));
        check("crash.ge19",   32'(b_dist >= 16'd19), 32'd1);
        b_tick = 1'b0; b_play = 1'b0;
        cycle();

        // ---------------- same run, jump on the fatal step ----------------
        rst = 1'b1; cycle(); rst = 1'b0;
        repeat (d) cycle();
        b_play = 1'b1; cycle();
        b_tick = 1'b1;
        jumped_once = 1'b0;
        guard = 0;
        while (!jumped_once && !b_dead && guard < 400) begin
            fatal = m_obs[1][1] && (m_air[1] == 0);
            b_jump = fatal;
            cycle();
            guard++;
            if (b_jump) begin
                jumped_once = 1'b1;
                b_jump = 1'b0;
                check("jmp.same_step", b_dist, 16'(crash_dist));
                check("jmp.alive",     b_dead, 1'b0);
                check("jmp.air",       b_air,  1'b1);
                air_cycles = 1;
                b_jump = 1'b1;                 // ignored: already airborne
                cycle();
                b_jump = 1'b0;
                while (b_air && air_cycles < 10) begin
                    air_cycles++;
                    cycle();
                end
                check("jmp.air_steps", air_cycles, 32'd3);
            end
        end
        check("jmp.done", jumped_once, 1'b1);
        b_tick = 1'b0; b_play = 1'b0; b_jump = 1'b0;
        cycle();

        // ---------------- mid-run drop ----------------
        b_play = 1'b1; cycle();
        b_tick = 1'b1;
        guard = 0;
        while (b_dist != 16'd5 && guard < 50) begin
            cycle();
            guard++;
        end
        check("drop.at5", b_dist, 16'd5);
        b_play = 1'b0;
        cycle();
        check("drop.obs",   b_obs,  16'd0);
        check("drop.dist",  b_dist, 16'd0);
        check("drop.flags", {b_win, b_dead, b_air, b_step}, 4'd0);
        b_play = 1'b1;
        cycle();
        repeat (15) cycle();
        check("drop.restart_dist", b_dist, 16'd15);
        check("drop.restart_flags", {b_win, b_dead}, 2'd0);

        // ---------------- generator gap, 500 steps ----------------
        steps = 0;
        guard = 0;
        while (steps < 500 && guard < 5000) begin
            guard++;
            if (m_ph[1] == P_WON || m_ph[1] == P_DEAD) begin
                b_play = 1'b0; b_tick = 1'b0; b_jump = 1'b0;
                cycle();
                b_play = 1'b1;
                cycle();
            end else begin
                b_tick = ($urandom_range(0, 3) != 0);
                b_jump = (b_tick && m_obs[1][1] && m_air[1] == 0) ||
                         ($urandom_range(0, 15) == 0);
                cycle();
                if (b_step) steps++;
            end
        end
        check("gap.steps", 32'(steps >= 500), 32'd1);
        b_play = 1'b0; b_tick = 1'b0; b_jump = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obstacle_play_engine.md
# obstacle_play_engine

Gameplay core for the obstacle runner. It scrolls a one-row obstacle field toward the player and applies jump input. It produces the `win` and `dead` status consumed by the top-level screen/game-state controller. It runs only while that controller holds `play` high, which corresponds to the playing screen, and it is cleared whenever `play` drops.

## Interface
Parameters:
- `COLS`, 16: playfield width in columns; column 0 is the player column.
- `WIN_DIST`, 256: number of scroll steps survived to win (≥1).
- `TICKS_PER_STEP`, 4: `tick` pulses per scroll step (≥1).
- `JUMP_STEPS`, 3: scroll steps the player stays airborne per jump (≥1).
- `MIN_GAP`, 3: minimum number of empty columns generated between obstacles.
- `LFSR_SEED`, 8'hA5: LFSR reset value (non-zero).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `play`  in  1  high while the game controller is in the playing state.
- `tick`  in  1  one-cycle frame pulse.
- `jump`  in  1  one-cycle debounced button pulse.
- `win`  out  1  level; high in WON.
- `dead`  out  1  level; high in CRASHED.
- `obstacles`  out  COLS  obstacle map; bit i set = obstacle in column i.
- `airborne`  out  1  `air_cnt != 0`.
- `distance`  out  16  scroll steps completed in the current run.
- `step`  out  1  one-cycle pulse, registered, high the cycle after each scroll step.

## Operation
- States: IDLE, RUN, WON, CRASHED. Reset → IDLE.
- **IDLE**
  - Clears `obstacles`, `distance`, `air_cnt`, `tick_cnt` and `gap_cnt`.
  - Moves to RUN when `play=1`.
- **RUN**
  - `play=0` → IDLE. This has priority over all other RUN activity.
  - **Jump:** when `jump=1` and `air_cnt==0`, load `air_cnt=JUMP_STEPS`. A jump while airborne is ignored; there is no buffering.
  - **Tick counting:** on `tick`, `tick_cnt` increments.
  - **Scroll step:** when `tick` arrives with `tick_cnt==TICKS_PER_STEP-1`, `tick_cnt` returns to 0 and a scroll step executes:
    - `new_bit = lfsr[0] & (gap_cnt >= MIN_GAP)`.
    - `nxt_obs = {new_bit, obstacles[COLS-1:1]}`.
    - `gap_cnt` becomes 0 if `new_bit`, otherwise `gap_cnt+1`, saturating at `MIN_GAP`.
    - `air_cnt` decrements if it is non-zero. If a jump is loaded in the same cycle, the loaded `JUMP_STEPS` wins and no decrement occurs.
    - `distance` increments.
    - **Collision:** `nxt_obs[0]==1` and the post-update `air_cnt==0` → CRASHED.
    - **Win:** otherwise, when the new `distance==WIN_DIST` → WON.
    - If collision and win occur on the same step, `dead` takes priority.
- **WON / CRASHED**
  - Freeze `obstacles`, `distance` and `air_cnt`.
  - Ignore `tick` and `jump`.
  - Move to IDLE when `play=0`.
- **LFSR**
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting every clock in every state.
  - Reset only by `reset`, so run contents depend on time spent in the menus.
- `win` and `dead` are never high together.

## Timing
- Reset values:
  - `win=0`, `dead=0`, `obstacles=0`, `airborne=0`, `distance=0`, `step=0`.
  - `lfsr=LFSR_SEED`.
  - State IDLE.
- IDLE→RUN takes 1 cycle after `play` rises. Ticks seen in the entry cycle are ignored.
- Outputs are registered. `obstacles`, `distance`, `win`/`dead` and `step` are valid the cycle after the clock edge that samples the deciding `tick`.
- `airborne` rises the cycle after `jump` is sampled.
- `play` low for one cycle in any state → IDLE on the next cycle, with all run state cleared. This includes a mid-run drop.
- Earliest possible obstacle insertion is step `MIN_GAP+1`. Earliest possible collision is step `MIN_GAP+COLS`.
- Counters are sized for `WIN_DIST ≤ 65535`. `distance` never exceeds `WIN_DIST`.

## Test plan
- **Reset:** hold `reset` 2 cycles with `play=1` → all outputs 0, and the LFSR equals 8'hA5 on the first cycle after release.
- **Guaranteed win:** `COLS=16`, `MIN_GAP=3`, `WIN_DIST=10`, `TICKS_PER_STEP=4`, no jumps, 40 ticks → `win=1` the cycle after tick 40; `distance=10`; `dead=0`; further ticks leave all outputs unchanged.
- **Crash:** `TICKS_PER_STEP=1`, no jumps, `WIN_DIST=200` → `dead=1` on exactly the step where the bench LFSR model places an obstacle in column 0. The step must be ≥ 19, and `distance` must match the model.
- **Jump over:** the same run as the crash scenario, but `jump` pulsed coincident with the fatal step → `air_cnt=3`, no crash on that step, and `airborne` falls after 3 steps. A second `jump` while airborne leaves `air_cnt` unchanged.
- **Generator gap:** run 500 steps with jumps scheduled by the model → every pair of set bits observed in `obstacles` is separated by ≥3 zero columns.
- **Mid-run drop:** drop `play` for 1 cycle at step 5 → next cycle shows IDLE, `obstacles=0`, `distance=0`; on re-raise, the run restarts from `distance` 0 with no stale `win`/`dead`.
